mag_comp_serial: RTL and testbench

//   Parametrised, digit-serial, MSB-first magnitude comparator, the multi-bit successor of the 1-bit LT/EQ/GT comparator.

---
 rtl/mag_comp_serial.sv | 120 ++++++++++++
 tb/tb_mag_comp_serial.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_comp_serial.sv
// Digit-serial MSB-first magnitude comparator with valid/ready capture and early exit.
// Optional two's-complement compare is enabled by defining CMP_SIGNED_EN.
module mag_comp_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    localparam int NDIG = WIDTH / DIGIT,
    localparam int CW   = $clog2(NDIG) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [CW-1:0]    ndigits,
    output logic [1:0]       fsm_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the source holds valid and data stable until then, and ready never depends on valid.

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] flip;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
    assign flip = WIDTH'(signed_mode) << (WIDTH - 1);
`else
    assign flip = '0;
`endif

    assign dig_a     = a_q[int'(idx) * DIGIT +: DIGIT];
    assign dig_b     = b_q[int'(idx) * DIGIT +: DIGIT];
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            ndigits   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a ^ flip;
                        b_q      <= b ^ flip;
                        idx      <= IW'(NDIG - 1);
                        cnt      <= CW'(1);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (dig_a > dig_b) begin
                        gt        <= 1'b1;
                        ndigits   <= cnt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (dig_a < dig_b) begin
                        lt        <= 1'b1;
                        ndigits   <= cnt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == '0) begin
                        eq        <= 1'b1;
                        ndigits   <= cnt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        lt        <= 1'b0;
                        eq        <= 1'b0;
                        gt        <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_comp_serial.sv
// Self-checking bench for mag_comp_serial (WIDTH=16, DIGIT=4) with a behavioural reference model.
// The signed-compare scenario is exercised only when CMP_SIGNED_EN is defined.
module tb_mag_comp_serial;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CW    = $clog2(NDIG) + 1;
    localparam int EW    = 3 + CW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             lt, eq, gt;
    logic [CW-1:0]    ndigits;
    logic [1:0]       fsm_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    mag_comp_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
`ifdef CMP_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lt(lt),
        .eq(eq),
        .gt(gt),
        .ndigits(ndigits),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] pack(input logic l, input logic e, input logic g, input int nd);
        return {l, e, g, CW'(nd)};
    endfunction

    // Reference: ordering from plain integer compare, digit count from the first differing digit.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic sm);
        logic [WIDTH-1:0] dmask;
        int nd;
        logic found;
        logic l, g;
        dmask = WIDTH'((1 << DIGIT) - 1);
        nd = NDIG;
        found = 1'b0;
        for (int d = NDIG - 1; d >= 0; d--) begin
            if (!found && (((x >> (d * DIGIT)) & dmask) != ((y >> (d * DIGIT)) & dmask))) begin
                nd = NDIG - d;
                found = 1'b1;
            end
        end
        l = sm ? ($signed(x) < $signed(y)) : (x < y);
        g = sm ? ($signed(x) > $signed(y)) : (x > y);
        return pack(l, x == y, g, nd);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: present operands, wait for the accept edge, then scramble the bus
    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic sm,
                        input logic [EW-1:0] expv);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        a = va;
        b = vb;
`ifdef CMP_SIGNED_EN
        signed_mode = sm;
`else
        signed_mode = 1'b0;
        if (sm) $display("note: signed request ignored in unsigned build");
`endif
        exp_q.push_back(expv);
        tick();
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        signed_mode = 1'b0;
    endtask

    // scoreboard: wait for the result, check latency, hold it under backpressure, then consume
    task automatic collect(input int hold);
        int lat;
        logic [EW-1:0] expv;
        logic [EW-1:0] got;
        lat = 0;
        while (!out_valid && lat < NDIG + 2) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_ready: in_ready=%b required 0", in_ready);
            end
            tick();
            lat++;
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        got = {lt, eq, gt, ndigits};
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
        end
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL result: lt/eq/gt/nd=%b required %b", got, expv);
        end
        checks++;
        if (lat != int'(expv[CW-1:0])) begin
            errors++;
            $display("FAIL latency: %0d cycles required %0d", lat, expv[CW-1:0]);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || {lt, eq, gt, ndigits} !== got || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold: valid=%b res=%b in_ready=%b required 1 %b 0",
                         out_valid, {lt, eq, gt, ndigits}, in_ready, got);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: valid=%b flags=%b in_ready=%b required 0 000 1",
                     out_valid, {lt, eq, gt}, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000 || ndigits !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b flags=%b nd=%0d required 1 0 000 0",
                     in_ready, out_valid, {lt, eq, gt}, ndigits);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        send(16'h1234, 16'h1235, 1'b0, pack(1, 0, 0, 4));
        collect(0);
        send(16'h9000, 16'h1000, 1'b0, pack(0, 0, 1, 1));
        collect(0);
        send(16'hBEEF, 16'hBEEF, 1'b0, pack(0, 1, 0, 4));
        collect(1);
        send(16'h0000, 16'hFFFF, 1'b0, pack(1, 0, 0, 1));
        collect(0);
        send(16'hAB70, 16'hAB0F, 1'b0, pack(0, 0, 1, 3));
        collect(0);
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] got;
        send(16'h1234, 16'h1235, 1'b0, pack(1, 0, 0, 4));
        for (int i = 0; i < NDIG + 2 && !out_valid; i++) tick();
        got = {lt, eq, gt, ndigits};
        checks++;
        if (out_valid !== 1'b1 || got !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_result: valid=%b res=%b required 1 %b", out_valid, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        in_valid = 1'b1;
        a = 16'h9000;
        b = 16'h1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || {lt, eq, gt, ndigits} !== got || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b res=%b in_ready=%b required 1 %b 0",
                         out_valid, {lt, eq, gt, ndigits}, in_ready, got);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        exp_q.push_back(pack(0, 0, 1, 1));
        tick();
        in_valid = 1'b0;
        a = 16'h0000;
        b = 16'hFFFF;
        collect(0);
    endtask

    task automatic test_signed();
`ifdef CMP_SIGNED_EN
        send(16'hFFFF, 16'h0001, 1'b1, pack(1, 0, 0, 1));
        collect(0);
        send(16'hFFFF, 16'h0001, 1'b0, pack(0, 0, 1, 1));
        collect(0);
        send(16'h8000, 16'h7FFF, 1'b1, pack(1, 0, 0, 1));
        collect(0);
`endif
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            send(16'h1234, 16'h1235, 1'b0, pack(1, 0, 0, 4));
            for (int i = 0; i < ((k == 0) ? 2 : 6); i++) tick();
            rst_n = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000 || in_ready !== 1'b1 || ndigits !== '0) begin
                errors++;
                $display("FAIL mid_reset%0d: valid=%b flags=%b in_ready=%b nd=%0d required 0 000 1 0",
                         k, out_valid, {lt, eq, gt}, in_ready, ndigits);
            end
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset%0d: in_ready=%b valid=%b required 1 0", k, in_ready, out_valid);
            end
            send(16'h1234, 16'h1235, 1'b0, pack(1, 0, 0, 4));
            collect(0);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] va, vb, mask;
        logic sm;
        int j;
        for (int n = 0; n < 40; n++) begin
            va = WIDTH'($urandom);
            j = $urandom_range(0, NDIG);
            mask = (j == NDIG) ? '0 : WIDTH'((32'd1 << ((NDIG - j) * DIGIT)) - 1);
            vb = (va & ~mask) | (WIDTH'($urandom) & mask);
`ifdef CMP_SIGNED_EN
            sm = 1'($urandom_range(0, 1));
`else
            sm = 1'b0;
`endif
            send(va, vb, sm, model(va, vb, sm));
            collect($urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int cyc;
        logic [EW-1:0] expv;
        done_cnt = 0;
        cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = WIDTH'($urandom);
        b = (a & 16'hFF00) | WIDTH'($urandom_range(0, 255));
        while (done_cnt < 20 && cyc < 400) begin
            if (in_valid && in_ready) exp_q.push_back(model(a, b, 1'b0));
            if (out_valid) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if ({lt, eq, gt, ndigits} !== expv) begin
                    errors++;
                    $display("FAIL b2b result %0d: %b required %b", done_cnt, {lt, eq, gt, ndigits}, expv);
                end
                done_cnt++;
            end
            tick();
            cyc++;
            if (!in_ready) begin
                a = WIDTH'($urandom);
                b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (done_cnt != 20) begin
            errors++;
            $display("FAIL b2b_count: %0d results required 20", done_cnt);
        end
        for (int i = 0; i < NDIG + 3; i++) begin
            if (out_valid) begin
                out_ready = 1'b1;
                void'(exp_q.pop_front());
            end
            tick();
            out_ready = 1'b0;
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_signed();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
